// File: rtl/farc_addsub_pipe.sv
// Pipelined sign-magnitude / 2's-complement adder-subtractor with valid/ready flow control.
// Optional saturation of overflowing results: define FARC_ADDSUB_SAT_EN.
module farc_addsub_pipe #(
  parameter int unsigned ADDER_WIDTH = 32,
  parameter int unsigned STAGES      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH-1:0] fa_a_in,
  input  logic [ADDER_WIDTH-1:0] fa_b_in,
  input  logic                   sm2c_sel,
  input  logic                   addsub_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDER_WIDTH-1:0] fa_sum_out,
  output logic                   fa_carry_out,
  output logic                   ovf_out,
  output logic                   zero_out
);
  localparam int unsigned W  = ADDER_WIDTH;
  localparam int unsigned S  = W / STAGES;
  localparam int unsigned LO = (STAGES - 1) * S;
  localparam logic [W:0]   MAG_MAX  = {2'b00, {(W-1){1'b1}}};
  localparam logic [W-1:0] LOW_MASK = (W'(1) << LO) - W'(1);

  logic         advance_c;
  logic [W:0]   a_ext_c, b_ext_c;
  logic         cin_c;
  logic [W:0]   l_a, l_b;
  logic [W-1:0] l_s;
  logic         l_c, l_sm, l_v;
  logic [S:0]   r_hi_c;
  logic [W:0]   r_c, mag_c;
  logic [W-1:0] sum_c;
  logic         carry_2c_c, carry_c, ovf_c, zero_c;
  logic         out_valid_q, carry_q, ovf_q, zero_q;
  logic [W-1:0] sum_q;

  // One global stall: the whole pipe moves only when the output slot can move.
  assign advance_c = ~out_valid_q | out_ready;
  assign in_ready  = advance_c;

  function automatic logic [W:0] conv(input logic [W-1:0] x, input logic sm);
    logic [W:0] m;
    m = {2'b00, x[W-2:0]};
    if (!sm) return {x[W-1], x};
    return x[W-1] ? -m : m;
  endfunction

  always_comb begin : p_conv
    a_ext_c = conv(fa_a_in, sm2c_sel);
    b_ext_c = conv(fa_b_in, sm2c_sel);
    cin_c   = addsub_sel;
    if (addsub_sel) b_ext_c = ~b_ext_c;
  end

  generate
    if (STAGES == 1) begin : g_single
      assign l_a  = a_ext_c;
      assign l_b  = b_ext_c;
      assign l_s  = '0;
      assign l_c  = cin_c;
      assign l_sm = sm2c_sel;
      assign l_v  = in_valid;
    end else begin : g_multi
      localparam int unsigned P = STAGES - 1;
      logic [P-1:0] v_q, sm_q, c_q, c_d;
      logic [W:0]   a_q [P];
      logic [W:0]   b_q [P];
      logic [W-1:0] s_q [P];
      logic [W-1:0] s_d [P];

      // Segment k sums its slice with the carry registered by segment k-1.
      always_comb begin : p_seg
        for (int k = 0; k < int'(P); k++) begin
          s_d[k] = '0;
          c_d[k] = 1'b0;
        end
        {c_d[0], s_d[0][S-1:0]} = {1'b0, a_ext_c[S-1:0]} + {1'b0, b_ext_c[S-1:0]} + (S+1)'(cin_c);
        for (int k = 1; k < int'(P); k++) begin
          s_d[k] = s_q[k-1];
          {c_d[k], s_d[k][k*S +: S]} = {1'b0, a_q[k-1][k*S +: S]} + {1'b0, b_q[k-1][k*S +: S]}
                                       + (S+1)'(c_q[k-1]);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin : p_valid
        if (!rst_n) begin
          v_q <= '0;
        end else if (flush_in) begin
          v_q <= '0;
        end else if (advance_c) begin
          v_q <= P'({v_q, in_valid});
        end
      end

      always_ff @(posedge clk) begin : p_data
        if (advance_c) begin
          a_q[0] <= a_ext_c;
          b_q[0] <= b_ext_c;
          for (int k = 1; k < int'(P); k++) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
          end
          s_q  <= s_d;
          c_q  <= c_d;
          sm_q <= P'({sm_q, sm2c_sel});
        end
      end

      assign l_a  = a_q[P-1];
      assign l_b  = b_q[P-1];
      assign l_s  = s_q[P-1];
      assign l_c  = c_q[P-1];
      assign l_sm = sm_q[P-1];
      assign l_v  = v_q[P-1];
    end
  endgenerate

  // Last segment including the extension bit, then mode-dependent formatting.
  always_comb begin : p_last
    r_hi_c     = (S+1)'((l_a >> LO) + (l_b >> LO) + (W+1)'(l_c));
    r_c        = ((W+1)'(r_hi_c) << LO) | (W+1)'(l_s & LOW_MASK);
    carry_2c_c = r_c[W] ^ l_a[W] ^ l_b[W];
    mag_c      = r_c[W] ? -r_c : r_c;
    sum_c      = r_c[W-1:0];
    ovf_c      = r_c[W] ^ r_c[W-1];
    carry_c    = carry_2c_c;
    if (l_sm) begin
      ovf_c   = mag_c > MAG_MAX;
      carry_c = ovf_c;
      sum_c   = {r_c[W] & (|mag_c[W-2:0]), mag_c[W-2:0]};
`ifdef FARC_ADDSUB_SAT_EN
      if (ovf_c) sum_c = {r_c[W], {(W-1){1'b1}}};
    end else if (ovf_c) begin
      sum_c = r_c[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    end
    zero_c = (sum_c == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_out
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (flush_in) begin
      out_valid_q <= 1'b0;
    end else if (advance_c) begin
      out_valid_q <= l_v;
      sum_q       <= sum_c;
      carry_q     <= carry_c;
      ovf_q       <= ovf_c;
      zero_q      <= zero_c;
    end
  end

  assign out_valid    = out_valid_q;
  assign fa_sum_out   = sum_q;
  assign fa_carry_out = carry_q;
  assign ovf_out      = ovf_q;
  assign zero_out     = zero_q;

endmodule

// File: doc/farc_addsub_pipe.md
Name: farc_addsub_pipe

Overview:
- Parametrised, pipelined successor to the ripple-carry adder/subtractor.
- Each transaction carries its own mode: sign-magnitude or 2's complement, add or subtract.
- The carry chain is split into STAGES registered segments, and a valid/ready handshake runs on both sides.
- Sits between operand-issue logic and result consumers in the datapath, with flags for overflow, zero and carry.

Parameters:
- ADDER_WIDTH, 32, operand/result width W. W >= 4 and W % STAGES == 0.
- STAGES, 4, pipeline depth and carry segments, each W/STAGES bits. Range 1..W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- flush_in  in  1  synchronous clear of all in-flight transactions
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat
- fa_a_in  in  W  operand A
- fa_b_in  in  W  operand B
- sm2c_sel  in  1  1 = sign-magnitude, 0 = 2's complement; captured with operands
- addsub_sel  in  1  0 = A+B, 1 = A-B; captured with operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- fa_sum_out  out  W  result
- fa_carry_out  out  1  carry flag
- ovf_out  out  1  signed/magnitude overflow
- zero_out  out  1  result is zero

Behaviour:
- Reset (rst_n=0, async): all stage valid bits 0, out_valid=0, fa_sum_out=0, fa_carry_out=0, ovf_out=0, zero_out=0. in_ready=1 after reset deasserts. Datapath registers need no reset.
- Handshake:
  - Beat accepted when in_valid & in_ready.
  - Result retired when out_valid & out_ready.
  - Global stall: advance = ~out_valid | out_ready; in_ready = advance.
  - Outputs hold stable while out_valid & ~out_ready.
- Latency: exactly STAGES cycles from accept to out_valid when unstalled. Throughput: 1 per cycle.
- Ordering: strict FIFO order. No drop, no duplication.
- Input conversion (stage 0, combinational before the first register):
  - Operands are extended to W+1 bits.
  - 2C mode: sign-extend.
  - SM mode: magnitude m = bits[W-2:0]; value = sign ? -m : m. -0 (sign=1, m=0) maps to 0.
  - Subtract: B operand is inverted and carry-in is 1, in both modes.
- Carry pipeline:
  - Stage k adds bits [k*S +: S], with S = W/STAGES, using the registered carry from stage k-1.
  - Unprocessed upper operand bits and completed lower sum bits are skewed through registers.
  - Bit W (extension) is resolved in the last stage.
- Output formatting (last stage), with 2C result r[W:0]:
  - 2C mode: fa_sum_out = r[W-1:0]; fa_carry_out = carry out of bit W-1; ovf_out = r[W] ^ r[W-1].
  - SM mode: sign = r[W]; mag = |r|. ovf_out = mag > 2^(W-1)-1. fa_sum_out = {sign, mag[W-2:0]}. If mag[W-2:0]==0 then sign is forced to 0 (no -0 output). fa_carry_out = ovf_out.
  - zero_out = (fa_sum_out[W-1:0]==0) after formatting and after saturation when enabled.
- flush_in:
  - Clears all stage valid bits and out_valid on the next edge.
  - A beat presented in the same cycle as flush is discarded.
  - Flush has priority over stall.
- Reset mid-operation: all in-flight transactions are lost. The output returns to reset values immediately (async).
- STAGES=1: a single registered stage with latency 1.

Optional Feature:
- Macro FARC_ADDSUB_SAT_EN.
- Defined: on ovf_out=1, the result saturates.
  - 2C mode: 0x7F..F if r[W]=0, else 0x80..0.
  - SM mode: {sign, all-ones magnitude}.
  - ovf_out still asserts. fa_carry_out is unchanged.
- Undefined: the result is wrapped/truncated as described above, and no saturation logic is present.

Test Plan (W=8, STAGES=2 unless noted):
- SM add 0x05 + 0x83 (+5 + -3) -> fa_sum_out=0x02, ovf=0, zero=0, out_valid exactly 2 cycles after accept.
- SM sub 0x03 - 0x05 -> 0x82. SM add 0x85 + 0x05 (-5 + 5) -> 0x00, zero=1 (never 0x80).
- 2C add 0x7F + 0x01 -> 0x80, ovf=1, carry=0. 2C sub 0x00 - 0x01 -> 0xFF, carry=0, ovf=0.
  - With FARC_ADDSUB_SAT_EN: 0x7F + 0x01 -> 0x7F, ovf=1. SM 0x7F + 0x01 -> 0x7F, ovf=1.
  - Without FARC_ADDSUB_SAT_EN: SM 0x7F + 0x01 -> 0x00, ovf=1.
- Backpressure: 6 back-to-back beats with mixed modes, out_ready low for cycles 3-5 -> in_ready low while stalled, all 6 results in order, outputs stable while stalled.
- flush_in pulsed with 2 beats in flight plus 1 presented -> no out_valid for those 3; the next beat returns correctly after 2 cycles. rst_n pulsed mid-stream -> outputs zero immediately, in_ready=1 after release.
- Sweep STAGES in {1, 4, 8} with W=8: random 10k operands/modes versus a reference model; latency == STAGES.
